// File: rtl/pool_pkg.sv
// Shared constants, types and helpers for the 2x2 multi-channel pooling engine.
package pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;
    localparam logic STRIDE2  = 1'b0;
    localparam logic STRIDE1  = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Stage-1 control that travels alongside the captured samples.
    typedef struct packed {
        logic vld;
        logic out;
        logic use_top;
        logic use_left;
        logic last;
    } s1_ctrl_t;

    // Right-shift that divides a window sum by its valid sample count (1, 2 or 4).
    function automatic logic [1:0] avg_shift(input logic [2:0] n);
        case (n)
            3'd4:    return 2'd2;
            3'd2:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/line_buf_sdp.sv
// Simple dual-port line buffer with a registered read port.
module line_buf_sdp #(
    parameter int DEPTH = 32,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sclk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Same-address read and write return the old contents (read-before-write).
    always_ff @(posedge sclk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/max_pool_nch.sv
// 2x2 max/average pooling over CH parallel channels of a raster pixel stream.
// Two-stage pipeline: window capture, then per-channel reduction into the output register.
module max_pool_nch
    import pool_pkg::*;
#(
    parameter int CH    = 8,
    parameter int DW    = 8,
    parameter int MAX_W = 32,
    parameter int WW    = $clog2(MAX_W + 1)
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             padding_start,
    input  logic             pool_stride,
    input  logic             pool_mode,
    input  logic [WW-1:0]    img_w,
    input  logic [WW-1:0]    img_h,
    input  logic [CH*DW-1:0] data_in,
    input  logic             data_in_vld,
    output logic [CH*DW-1:0] data_out,
    output logic             data_out_vld,
    output logic             frame_done,
    output logic             busy
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    state_t                 state, state_nxt;
    logic                   cfg_stride, cfg_mode;
    logic [WW-1:0]          cfg_w, cfg_h, col, row;
    logic                   accept, last_pix;
    logic [CH*DW-1:0]       rd_data;
    logic [CH-1:0][DW-1:0]  cur_q, left_q, tl_q, top_d, res;
    s1_ctrl_t               s1;
    logic [2:0]             n_win;
    logic [1:0]             shamt;

    assign busy     = (state == ST_RUN);
    assign accept   = busy && data_in_vld && !padding_start && (row < cfg_h);
    assign last_pix = (row == cfg_h - WW'(1)) && (col == cfg_w - WW'(1));
    assign top_d    = rd_data;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // A new padding_start always restarts, even over a frame that is finishing.
    always_comb begin
        state_nxt = state;
        if (padding_start)                             state_nxt = ST_RUN;
        else if (state == ST_RUN && s1.vld && s1.last) state_nxt = ST_IDLE;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cfg_stride <= 1'b0;
            cfg_mode   <= 1'b0;
            cfg_w      <= '0;
            cfg_h      <= '0;
            col        <= '0;
            row        <= '0;
        end else if (padding_start) begin
            cfg_stride <= pool_stride;
            cfg_mode   <= pool_mode;
            cfg_w      <= img_w;
            cfg_h      <= img_h;
            col        <= '0;
            row        <= '0;
        end else if (accept) begin
            if (col == cfg_w - WW'(1)) begin
                col <= '0;
                row <= row + WW'(1);
            end else begin
                col <= col + WW'(1);
            end
        end
    end

    line_buf_sdp #(.DEPTH(MAX_W), .W(CH*DW), .AW(AW)) u_line_buf (
        .sclk    (sclk),
        .wr_en   (accept),
        .wr_addr (col[AW-1:0]),
        .wr_data (data_in),
        .rd_en   (accept),
        .rd_addr (col[AW-1:0]),
        .rd_data (rd_data)
    );

    // Stage 1: the previous accepted pixel is the left neighbour, the previous RAM read the top-left.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            s1     <= '0;
            cur_q  <= '0;
            left_q <= '0;
            tl_q   <= '0;
        end else if (padding_start) begin
            s1     <= '0;
            cur_q  <= '0;
            left_q <= '0;
            tl_q   <= '0;
        end else begin
            s1.vld <= accept;
            if (accept) begin
                cur_q       <= data_in;
                left_q      <= cur_q;
                tl_q        <= top_d;
                s1.out      <= (cfg_stride == STRIDE1) || (row[0] && col[0]);
                s1.use_top  <= (row != '0);
                s1.use_left <= (col != '0);
                s1.last     <= last_pix;
            end
        end
    end

    assign n_win = (s1.use_top && s1.use_left) ? 3'd4 :
                   (s1.use_top || s1.use_left) ? 3'd2 : 3'd1;
    assign shamt = avg_shift(n_win);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [DW-1:0] l, t, tl, m0, m1, r;
        logic [DW+1:0] sum;
        // Out-of-frame samples are zeroed: neutral for both unsigned max and sum.
        always_comb begin
            l   = s1.use_left ? left_q[k] : '0;
            t   = s1.use_top ? top_d[k] : '0;
            tl  = (s1.use_left && s1.use_top) ? tl_q[k] : '0;
            m0  = (cur_q[k] > l) ? cur_q[k] : l;
            m1  = (t > tl) ? t : tl;
            sum = {2'b00, cur_q[k]} + {2'b00, l} + {2'b00, t} + {2'b00, tl};
            if (cfg_mode == POOL_AVG) r = DW'(sum >> shamt);
            else                      r = (m0 > m1) ? m0 : m1;
        end
        assign res[k] = r;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            data_out     <= '0;
            data_out_vld <= 1'b0;
            frame_done   <= 1'b0;
        end else if (padding_start) begin
            data_out_vld <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            data_out_vld <= s1.vld && s1.out;
            frame_done   <= s1.vld && s1.last;
            if (s1.vld && s1.out) data_out <= res;
        end
    end

endmodule
